reg_file_mp: RTL and testbench

Parametrised multi-read-port, dual-write-port register file. It is the successor to the fixed 32x32 two-read/one-write file in the core datapath.
- Adds write-to-read bypass, an optional hardwired zero register, and a per-entry busy scoreboard for hazard detection.
- Adds a sequential clear engine that zeroes the whole array without asserting reset.
- Sits between decode (reads, scoreboard set) and write-back (two write ports).

---
 rtl/reg_file_mp.sv | 115 +++++++++++
 tb/tb_reg_file_mp.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-read, dual-write register file with write-to-read bypass, optional zero register,
// per-entry busy scoreboard and a sequential clear engine that zeroes one entry per cycle.
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    output logic [NREAD-1:0]        rd_busy,
    input  logic                    wr0_en,
    input  logic [ADDR_W-1:0]       wr0_addr,
    input  logic [DATA_W-1:0]       wr0_data,
    input  logic                    wr1_en,
    input  logic [ADDR_W-1:0]       wr1_addr,
    input  logic [DATA_W-1:0]       wr1_data,
    input  logic                    sb_set_en,
    input  logic [ADDR_W-1:0]       sb_set_addr,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic                    clr_done
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  sb;
    logic [DEPTH-1:0]  sb_next;
    logic              idle;
    logic              wr0_eff;
    logic              wr1_eff;
    logic              sb_set_eff;

    assign idle       = (state == IDLE);
    assign wr0_eff    = wr0_en && idle && !(ZERO_REG != 0 && wr0_addr == '0);
    assign wr1_eff    = wr1_en && idle && !(ZERO_REG != 0 && wr1_addr == '0);
    assign sb_set_eff = sb_set_en && idle && !(ZERO_REG != 0 && sb_set_addr == '0);

    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(DEPTH - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // wr1 is assigned last so it wins when both ports hit the same entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            if (wr0_eff) mem[wr0_addr] <= wr0_data;
            if (wr1_eff) mem[wr1_addr] <= wr1_data;
        end
    end

    // set is applied after the clears so an issue and a write-back to one entry leaves it busy
    always_comb begin
        sb_next = sb;
        if (state == CLEAR) begin
            sb_next[cnt] = 1'b0;
        end else begin
            if (wr0_eff)    sb_next[wr0_addr]    = 1'b0;
            if (wr1_eff)    sb_next[wr1_addr]    = 1'b0;
            if (sb_set_eff) sb_next[sb_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sb <= '0;
        else       sb <= sb_next;
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit0;
        logic              hit1;

        assign a    = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit0 = wr0_eff && (wr0_addr == a);
        assign hit1 = wr1_eff && (wr1_addr == a);

        assign rd_data[i*DATA_W +: DATA_W] = (ZERO_REG != 0 && a == '0) ? '0 :
                                             hit1 ? wr1_data :
                                             hit0 ? wr0_data : mem[a];
        assign rd_busy[i] = sb[a] && !(hit0 || hit1);
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (zero register on / off) driven from shared inputs and
// checked every cycle against an array-based reference model, plus directed literal checks.
module tb_reg_file_mp;
    logic        clk;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data0, rd_data1;
    logic [1:0]  rd_busy0, rd_busy1;
    logic        wr0_en, wr1_en, sb_set_en, clr_req;
    logic [4:0]  wr0_addr, wr1_addr, sb_set_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        clr_busy0, clr_busy1, clr_done0, clr_done1;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1)) dut0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .clr_req(clr_req),
        .clr_busy(clr_busy0), .clr_done(clr_done0));

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0)) dut1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .clr_req(clr_req),
        .clr_busy(clr_busy1), .clr_done(clr_done1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = zero-register instance, 1 = ordinary instance
    logic [31:0] m_mem [2][32];
    bit          m_sb  [2][32];
    int          m_rem;
    bit          m_done;

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++) begin
                m_mem[k][a] = '0;
                m_sb[k][a]  = 1'b0;
            end
        m_rem  = 0;
        m_done = 1'b0;
    endtask

    function automatic bit m_idle();
        return (m_rem == 0) && !m_done;
    endfunction

    function automatic bit eff(int k, logic en, logic [4:0] addr);
        return en && m_idle() && !(k == 0 && addr == 5'd0);
    endfunction

    task automatic model_step();
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            for (int k = 0; k < 2; k++) begin
                m_mem[k][32 - m_rem] = '0;
                m_sb[k][32 - m_rem]  = 1'b0;
            end
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (eff(k, wr0_en, wr0_addr)) begin
                    m_mem[k][wr0_addr] = wr0_data;
                    m_sb[k][wr0_addr]  = 1'b0;
                end
                if (eff(k, wr1_en, wr1_addr)) begin
                    m_mem[k][wr1_addr] = wr1_data;
                    m_sb[k][wr1_addr]  = 1'b0;
                end
                if (sb_set_en && !(k == 0 && sb_set_addr == 5'd0)) m_sb[k][sb_set_addr] = 1'b1;
            end
            if (clr_req) m_rem = 32;
        end
    endtask

    function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
        if (k == 0 && a == 5'd0) return '0;
        if (eff(k, wr1_en, wr1_addr) && wr1_addr == a) return wr1_data;
        if (eff(k, wr0_en, wr0_addr) && wr0_addr == a) return wr0_data;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_busy(int k, logic [4:0] a);
        bit hit;
        hit = (eff(k, wr1_en, wr1_addr) && wr1_addr == a) || (eff(k, wr0_en, wr0_addr) && wr0_addr == a);
        return m_sb[k][a] && !hit;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) begin
                logic [4:0] a;
                a = rd_addr[p*5 +: 5];
                chk($sformatf("dut%0d rd_data[%0d] addr %0d", k, p, a),
                    (k == 0) ? rd_data0[p*32 +: 32] : rd_data1[p*32 +: 32], exp_rd(k, a));
                chk($sformatf("dut%0d rd_busy[%0d] addr %0d", k, p, a),
                    32'((k == 0) ? rd_busy0[p] : rd_busy1[p]), 32'(exp_busy(k, a)));
            end
            chk($sformatf("dut%0d clr_busy", k), 32'((k == 0) ? clr_busy0 : clr_busy1), 32'(m_rem > 0));
            chk($sformatf("dut%0d clr_done", k), 32'((k == 0) ? clr_done0 : clr_done1), 32'(m_done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wr0_en = 1'b0; wr1_en = 1'b0; sb_set_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic fill_index();
        for (int a = 1; a < 32; a++) begin
            wr0_en = 1'b1; wr0_addr = 5'(a); wr0_data = 32'(a);
            tick();
        end
        quiet();
    endtask

    task automatic run_clear(input int abort_at, output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        clr_req  = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (clr_busy0) busy_cnt++;
            if (clr_done0) done_cnt++;
            if (abort_at > 0 && busy_cnt == abort_at) return;
            wr0_en = (busy_cnt == 10) && clr_busy0;
            wr0_addr = 5'd3; wr0_data = 32'h33;
            tick();
        end
        quiet();
    endtask

    initial begin
        int bc, dc;
        reset = 1'b0;
        rd_addr = '0;
        wr0_addr = '0; wr1_addr = '0; sb_set_addr = '0;
        wr0_data = '0; wr1_data = '0;
        quiet();
        #2 reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // post-reset sweep
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #2;
            chk("reset rd_data", rd_data1[31:0], 32'h0);
            tick();
        end
        chk("reset clr_busy", 32'(clr_busy0), 32'h0);

        // bypass then array, then wr1 priority
        rd_addr = {5'd5, 5'd5};
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        #2 chk("bypass wr0", rd_data0[31:0], 32'hDEADBEEF);
        tick(); quiet();
        #2 chk("array wr0", rd_data0[31:0], 32'hDEADBEEF);
        wr0_en = 1'b1; wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 32'h12345678;
        #2 chk("bypass wr1 wins", rd_data0[31:0], 32'h12345678);
        tick(); quiet();
        #2 chk("array wr1 wins", rd_data0[63:32], 32'h12345678);

        // zero register
        wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
        sb_set_en = 1'b1; sb_set_addr = 5'd0;
        tick(); quiet();
        rd_addr = {5'd0, 5'd0};
        #2;
        chk("zr1 rd 0", rd_data0[31:0], 32'h0);
        chk("zr1 busy 0", 32'(rd_busy0[0]), 32'h0);
        chk("zr0 rd 0", rd_data1[31:0], 32'hFFFFFFFF);
        chk("zr0 busy 0", 32'(rd_busy1[0]), 32'h1);
        tick();

        // scoreboard
        sb_set_en = 1'b1; sb_set_addr = 5'd7; rd_addr = {5'd7, 5'd7};
        tick(); quiet();
        #2 chk("sb set 7", 32'(rd_busy0[0]), 32'h1);
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h77;
        #2 chk("sb bypass clear 7", 32'(rd_busy0[1]), 32'h0);
        tick(); quiet();
        #2 chk("sb stays clear 7", 32'(rd_busy0[0]), 32'h0);
        sb_set_en = 1'b1; sb_set_addr = 5'd9; wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h99;
        tick(); quiet();
        rd_addr = {5'd9, 5'd9};
        #2 chk("sb set wins 9", 32'(rd_busy0[0]), 32'h1);
        tick();

        // randomized traffic with occasional clears
        for (int c = 0; c < 600; c++) begin
            logic [4:0] hi;
            hi = ($urandom_range(0, 1) == 0) ? 5'd7 : 5'd31;
            wr0_en      = 1'($urandom_range(0, 1));
            wr1_en      = 1'($urandom_range(0, 1));
            sb_set_en   = 1'($urandom_range(0, 1));
            clr_req     = ($urandom_range(0, 59) == 0);
            wr0_addr    = 5'($urandom_range(0, 32'(hi)));
            wr1_addr    = 5'($urandom_range(0, 32'(hi)));
            sb_set_addr = 5'($urandom_range(0, 32'(hi)));
            wr0_data    = $urandom;
            wr1_data    = $urandom;
            rd_addr[4:0] = ($urandom_range(0, 1) == 0) ? wr0_addr : 5'($urandom_range(0, 32'(hi)));
            rd_addr[9:5] = ($urandom_range(0, 1) == 0) ? wr1_addr : 5'($urandom_range(0, 32'(hi)));
            tick();
        end
        quiet();
        for (int c = 0; c < 40; c++) tick();

        // full clear with a dropped mid-clear write
        fill_index();
        run_clear(0, bc, dc);
        chk("clear busy cycles", 32'(bc), 32'd32);
        chk("clear done pulses", 32'(dc), 32'd1);
        rd_addr = {5'd31, 5'd3};
        #2;
        chk("dropped write addr 3", rd_data0[31:0], 32'h0);
        chk("cleared addr 31", rd_data1[63:32], 32'h0);
        tick();

        // reset aborts a clear in progress
        fill_index();
        run_clear(10, bc, dc);
        reset = 1'b1;
        #1;
        chk("abort clr_busy", 32'(clr_busy0), 32'h0);
        chk("abort clr_done", 32'(clr_done0), 32'h0);
        tick(); tick();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(a), 5'(a)};
            #2;
            chk("after abort rd", rd_data1[31:0], 32'h0);
            tick();
        end
        run_clear(0, bc, dc);
        chk("rerun busy cycles", 32'(bc), 32'd32);
        chk("rerun done pulses", 32'(dc), 32'd1);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
